// File: rtl/bcd_display_seq_pkg.sv
// Purpose: shared 7-segment code constants, FSM state type and a digit-to-segment helper.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package bcd_display_seq_pkg;

  // Segment fields are ordered a..g from MSB to LSB and are active-low.
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0   = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Non-decimal nibbles never reach a display in normal operation; show blank.
  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_seq_dabble_step.sv
// Purpose: double-dabble correction, adds 3 to every BCD digit that is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module dabble_step #(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  // Correct each digit so the following left shift carries into the next digit.
  always_comb begin
    bcd_o = bcd_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_display_seq.sv
// Purpose: iterative binary-to-BCD conversion (one bit per clock) with registered 7-segment decode.
// Latency: start in cycle T gives done in cycle T+N+1; next start accepted in T+N+2.
// Backpressure: start is only honoured in IDLE; requests while converting are dropped, not queued.
module bcd_display_seq
  import bcd_display_seq_pkg::*;
#(
  parameter int N      = 20,
  parameter int DIGITS = 6,
  parameter int SEG    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS*SEG-1:0] display
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  state_t               state_q, state_d;
  logic [N-1:0]         shreg_q, shreg_d;
  logic [BW-1:0]        scr_q, scr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 blank_q, blank_d;
  logic                 ovf_int_q, ovf_int_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [DIGITS*SEG-1:0] disp_q, disp_d;

  logic [BW-1:0]        scr_adj;
  logic                 shift_out;
  logic [BW-1:0]        shift_scr;
  logic [N-1:0]         shift_sh;
  logic                 ovf_final;
  logic [BW-1:0]        res_bcd;
  logic [DIGITS*SEG-1:0] disp_dec;
  logic [DIGITS:0]      upper_nz;

  dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd_i (scr_q),
    .bcd_o (scr_adj)
  );

  // One step of the combined {scratch, shreg} left shift; the bit leaving the top digit flags overflow.
  assign {shift_out, shift_scr, shift_sh} = {scr_adj, shreg_q, 1'b0};
  assign ovf_final = ovf_int_q | shift_out;

  // Result as it will look after the final shift; saturate to all nines on overflow.
  assign res_bcd = ovf_final ? {DIGITS{4'h9}} : shift_scr;

  // Per-digit decode; a digit is blanked only if it and every digit above it are zero.
  assign upper_nz[DIGITS] = 1'b0;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] dig;
    logic       show;
    assign dig         = res_bcd[4*i +: 4];
    assign upper_nz[i] = upper_nz[i+1] | (dig != 4'd0);
    assign show        = (i == 0) || upper_nz[i] || !blank_q || ovf_final;
    assign disp_dec[SEG*i +: SEG] = show ? SEG'(seg_of(dig)) : {SEG{1'b1}};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath next values. Outputs are captured on the edge that
  // enters LOAD so that done and the new results are visible together in LOAD.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    ovf_int_d  = ovf_int_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          shreg_d   = bin;
          blank_d   = blank_lz;
          scr_d     = '0;
          ovf_int_d = 1'b0;
          cnt_d     = CW'(N);
          busy_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        shreg_d   = shift_sh;
        scr_d     = shift_scr;
        ovf_int_d = ovf_final;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = ST_LOAD;
          bcd_d      = res_bcd;
          disp_d     = disp_dec;
          overflow_d = ovf_final;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      blank_q    <= 1'b0;
      ovf_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
      disp_q     <= '1;
    end else begin
      shreg_q    <= shreg_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      ovf_int_q  <= ovf_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd      = bcd_q;
  assign display  = disp_q;

endmodule

// File: tb/tb_bcd_display_seq.sv
// Purpose: directed self-checking bench for bcd_display_seq with a result scoreboard.
// Latency: expects done exactly N+1 cycles after an accepted start.
// Backpressure: checks that starts during a conversion are dropped.
module tb_bcd_display_seq;

  localparam int N      = 20;
  localparam int DIGITS = 6;
  localparam int SEG    = 7;
  localparam int LAT    = N + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [N-1:0]          bin;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS*SEG-1:0] display;

  typedef struct packed {
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS*SEG-1:0] disp;
    logic                  ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  bcd_display_seq #(.N(N), .DIGITS(DIGITS), .SEG(SEG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd      (bcd),
    .display  (display)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model using decimal division, independent of double-dabble.
  function automatic exp_t model(input logic [N-1:0] b, input logic bl);
    exp_t   e;
    int     v;
    int     d [DIGITS];
    int     msd;
    logic   ovf;
    ovf = (int'(b) >= 1000000);
    v   = int'(b);
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = ovf ? 9 : v % 10;
      v    = v / 10;
      if (d[i] != 0) msd = i;
    end
    e.ovf = ovf;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(d[i]);
      if (bl && !ovf && i > 0 && i > msd) e.disp[SEG*i +: SEG] = 7'b1111111;
      else                                e.disp[SEG*i +: SEG] = seg_tbl[d[i]];
    end
    return e;
  endfunction

  // One conversion: pulse start, optionally re-pulse start at cycle offset ign_at,
  // then wait (bounded) for done and score the result.
  task automatic do_conv(input logic [N-1:0] b, input logic bl, input int ign_at, input string tag);
    int   lat;
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    bin      = b;
    blank_lz = bl;
    sbq.push_back(model(b, bl));
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == ign_at);
      bin   = N'(k * 7919);
      if (k == 1)  check({tag, "_busy"}, 64'(busy), 64'd1);
      if (k == 10) check({tag, "_hold"}, 64'(bcd), 64'(last_exp.bcd));
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, "_bcd"}, 64'(bcd), 64'(e.bcd));
      check({tag, "_display"}, 64'(display), 64'(e.disp));
      check({tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
      last_exp = e;
    end
  endtask

  task automatic no_done(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    bin      = '0;
    blank_lz = 1'b0;
    last_exp = '{bcd: '0, disp: '1, ovf: 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_display", 64'(display), 64'h3FF_FFFF_FFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // Main function, with a literal cross-check of the segment fields.
    do_conv(20'd123456, 1'b0, 0, "c123456");
    check("c123456_literal", 64'(display),
          64'({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000}));

    // Reset asserted mid-SHIFT: immediate reset values and no done afterwards.
    @(negedge clk);
    start = 1'b1;
    bin   = 20'd777;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_display", 64'(display), 64'h3FF_FFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    no_done(30, "midrst_no_done");
    check("midrst_busy_after", 64'(busy), 64'd0);
    last_exp = '{bcd: '0, disp: '1, ovf: 1'b0};

    // Boundaries around 10^DIGITS.
    do_conv(20'd999999, 1'b0, 0, "c999999");
    do_conv(20'd1000000, 1'b0, 0, "c1000000");
    check("c1000000_all9", 64'(display),
          64'({7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}));
    do_conv(20'd1048575, 1'b1, 0, "c1048575");

    // Leading-zero blanking.
    do_conv(20'd42, 1'b1, 0, "blank42");
    do_conv(20'd0, 1'b1, 0, "blank0");
    do_conv(20'd100500, 1'b1, 0, "blank100500");
    do_conv(20'd7, 1'b0, 0, "noblank7");

    // Start during conversion is dropped; then a fresh start works.
    do_conv(20'd777, 1'b0, 5, "ign777");
    no_done(25, "ign777_single_done");
    do_conv(20'd314159, 1'b0, 0, "fresh314159");

    // Back-to-back: second start in the first cycle IDLE is reachable again.
    do_conv(20'd5, 1'b0, 0, "b2b5");
    do_conv(20'd10, 1'b0, 0, "b2b10");

    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
